war_round_ctrl: RTL and testbench

Round controller for the human-vs-CPU tug-of-war playfield. It arbitrates between the human key (left side) and the LFSR-driven CPU press (right side), and issues one-cycle move pulses to the nine-light playfield. It detects round wins at the edge lights, keeps per-side scores, and sequences win display, playfield restart and game over. It sits between the input synchronizer/LFSR and the light-cell chain.

---
 rtl/war_pkg.sv | 22 ++
 rtl/war_edge_detect.sv | 21 ++
 rtl/war_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_war_round_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/war_pkg.sv
// Shared types for the tug-of-war round controller.
// Optional feature macro: WAR_ALT_PRIORITY_EN (alternating tie priority).
package war_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    WIN_HOLD = 2'd1,
    CLEAR    = 2'd2,
    OVER     = 2'd3
  } state_t;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

  // A hold of one cycle still needs a one-bit counter that loads zero.
  function automatic int hold_cnt_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/war_edge_detect.sv
// Registered rising-edge detector for the synchronized human key.
module war_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic level_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/war_round_ctrl.sv
// Round controller: arbitrates human/CPU presses, scores round wins, sequences restart and game over.
// Define WAR_ALT_PRIORITY_EN to make simultaneous presses alternate sides instead of cancelling.
module war_round_ctrl
  import war_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int LFSR_W      = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_l,
  input  logic [LFSR_W-1:0] lfsr_val,
  input  logic [LFSR_W-1:0] threshold,
  input  logic              leftmost_on,
  input  logic              rightmost_on,
  output logic              move_l,
  output logic              move_r,
  output logic              field_reset,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic              winner,
  output logic              game_over
);

  localparam int                 CNT_W     = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t           state;
  state_t           state_next;
  side_t            winner_q;
  logic [CNT_W-1:0] hold_cnt;
  logic             req_l;
  logic             req_r;
  logic             grant_l;
  logic             grant_r;
  logic             win_l;
  logic             win_r;
  logic             at_max;
`ifdef WAR_ALT_PRIORITY_EN
  side_t            tie_last;
  logic             tie;
`endif

  war_edge_detect u_key_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (key_l),
    .rise    (req_l)
  );

  assign req_r  = (lfsr_val > threshold);
  assign at_max = (score_l == SCORE_MAX) || (score_r == SCORE_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PLAY;
    end else begin
      state <= state_next;
    end
  end

  // Presses only count while playing; a win grant also ends the round.
  always_comb begin
    state_next = state;
    grant_l    = 1'b0;
    grant_r    = 1'b0;
    case (state)
      PLAY: begin
        if (req_l && req_r) begin
`ifdef WAR_ALT_PRIORITY_EN
          if (tie_last == SIDE_R) begin
            grant_l = 1'b1;
          end else begin
            grant_r = 1'b1;
          end
`else
          grant_l = 1'b0;
          grant_r = 1'b0;
`endif
        end else begin
          grant_l = req_l;
          grant_r = req_r;
        end
        if ((grant_l && leftmost_on) || (grant_r && rightmost_on)) begin
          state_next = WIN_HOLD;
        end
      end
      WIN_HOLD: begin
        if (hold_cnt == '0) begin
          state_next = at_max ? OVER : CLEAR;
        end
      end
      CLEAR: begin
        state_next = PLAY;
      end
      OVER: begin
        state_next = OVER;
      end
      default: begin
        state_next = PLAY;
      end
    endcase
  end

  assign win_l = grant_l & leftmost_on;
  assign win_r = grant_r & rightmost_on;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      move_l   <= 1'b0;
      move_r   <= 1'b0;
      score_l  <= '0;
      score_r  <= '0;
      winner_q <= SIDE_L;
      hold_cnt <= '0;
    end else begin
      move_l <= grant_l;
      move_r <= grant_r;
      if (win_l) begin
        if (score_l != SCORE_MAX) begin
          score_l <= score_l + SCORE_W'(1);
        end
        winner_q <= SIDE_L;
      end
      if (win_r) begin
        if (score_r != SCORE_MAX) begin
          score_r <= score_r + SCORE_W'(1);
        end
        winner_q <= SIDE_R;
      end
      if (win_l || win_r) begin
        hold_cnt <= CNT_LOAD;
      end else if ((state == WIN_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
    end
  end

`ifdef WAR_ALT_PRIORITY_EN
  assign tie = (state == PLAY) && req_l && req_r;

  // Reset to the right side so the very first tie is awarded to the human.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tie_last <= SIDE_R;
    end else if (tie) begin
      tie_last <= grant_l ? SIDE_L : SIDE_R;
    end
  end
`endif

  assign winner      = winner_q;
  assign field_reset = (state == CLEAR);
  assign game_over   = (state == OVER);

endmodule

// File: tb/tb_war_round_ctrl.sv
// Directed bench for war_round_ctrl with a timeline-based reference model checked every cycle.
module tb_war_round_ctrl;

  localparam int SW   = 3;
  localparam int HOLD = 4;
  localparam int LW   = 10;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          key_l = 1'b0;
  logic [LW-1:0] lfsr_val = '0;
  logic [LW-1:0] threshold = '1;
  logic          leftmost_on = 1'b0;
  logic          rightmost_on = 1'b0;
  logic          move_l;
  logic          move_r;
  logic          field_reset;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          winner;
  logic          game_over;

  int checks = 0;
  int failures = 0;

  war_round_ctrl #(.SCORE_W(SW), .HOLD_CYCLES(HOLD), .LFSR_W(LW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_l        (key_l),
    .lfsr_val     (lfsr_val),
    .threshold    (threshold),
    .leftmost_on  (leftmost_on),
    .rightmost_on (rightmost_on),
    .move_l       (move_l),
    .move_r       (move_r),
    .field_reset  (field_reset),
    .score_l      (score_l),
    .score_r      (score_r),
    .winner       (winner),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers the cycle of the last round win and derives hold/clear/over from elapsed time.
  int   m_t;
  int   m_win_t;
  bit   m_win_max;
  bit   m_key_prev;
  bit   m_tie_last;
  int   m_score_l;
  int   m_score_r;
  bit   m_winner;
  bit   exp_move_l;
  bit   exp_move_r;
  bit   exp_field_reset;
  bit   exp_game_over;

  function automatic bit busy(input int t);
    if (m_win_t < 0) return 1'b0;
    if (t <= m_win_t) return 1'b0;
    return m_win_max || (t <= m_win_t + HOLD + 1);
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit rl, rr, gl, gr, wn, wm, tl;
    int sl, sr, wt, nt;
    if (!reset_n) begin
      m_t <= 0;
      m_win_t <= -1;
      m_win_max <= 1'b0;
      m_key_prev <= 1'b0;
      m_tie_last <= 1'b1;
      m_score_l <= 0;
      m_score_r <= 0;
      m_winner <= 1'b0;
      exp_move_l <= 1'b0;
      exp_move_r <= 1'b0;
      exp_field_reset <= 1'b0;
      exp_game_over <= 1'b0;
    end else begin
      rl = key_l && !m_key_prev;
      rr = (lfsr_val > threshold);
      gl = 1'b0;
      gr = 1'b0;
      sl = m_score_l;
      sr = m_score_r;
      wn = m_winner;
      wt = m_win_t;
      wm = m_win_max;
      tl = m_tie_last;
      if (!busy(m_t)) begin
        if (rl && rr) begin
`ifdef WAR_ALT_PRIORITY_EN
          if (tl) gl = 1'b1;
          else    gr = 1'b1;
          tl = gr;
`endif
        end else begin
          gl = rl;
          gr = rr;
        end
      end
      if (gl && leftmost_on) begin
        if (sl < SMAX) sl = sl + 1;
        wn = 1'b0;
        wt = m_t;
      end
      if (gr && rightmost_on) begin
        if (sr < SMAX) sr = sr + 1;
        wn = 1'b1;
        wt = m_t;
      end
      if (wt == m_t) wm = (sl == SMAX) || (sr == SMAX);
      nt = m_t + 1;
      m_t <= nt;
      m_win_t <= wt;
      m_win_max <= wm;
      m_key_prev <= key_l;
      m_tie_last <= tl;
      m_score_l <= sl;
      m_score_r <= sr;
      m_winner <= wn;
      exp_move_l <= gl;
      exp_move_r <= gr;
      exp_field_reset <= (wt >= 0) && !wm && (nt == wt + HOLD + 1);
      exp_game_over <= (wt >= 0) && wm && (nt >= wt + HOLD + 1);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check_output("cyc_move_l", move_l, exp_move_l);
      check_output("cyc_move_r", move_r, exp_move_r);
      check_output("cyc_field_reset", field_reset, exp_field_reset);
      check_output("cyc_game_over", game_over, exp_game_over);
      check_output("cyc_score_l", score_l, m_score_l);
      check_output("cyc_score_r", score_r, m_score_r);
      check_output("cyc_winner", winner, m_winner);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input bit k, input int lfsr, input int thr, input bit lo, input bit ro);
    key_l = k;
    lfsr_val = LW'(lfsr);
    threshold = LW'(thr);
    leftmost_on = lo;
    rightmost_on = ro;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_move_l"}, move_l, 0);
    check_output({tag, "_move_r"}, move_r, 0);
    check_output({tag, "_field_reset"}, field_reset, 0);
    check_output({tag, "_score_l"}, score_l, 0);
    check_output({tag, "_score_r"}, score_r, 0);
    check_output({tag, "_winner"}, winner, 0);
    check_output({tag, "_game_over"}, game_over, 0);
  endtask

  initial begin
    int pulses;
    apply_stimulus(0, 0, 1023, 0, 0);
    tick(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // Single key press, CPU disabled.
    apply_stimulus(1, 0, 1023, 0, 0);
    tick();
    check_output("press_move_l", move_l, 1);
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();
    check_output("press_move_l_width", move_l, 0);
    check_output("press_score_l", score_l, 0);

    // Held key yields one pulse only.
    pulses = 0;
    apply_stimulus(1, 0, 1023, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (move_l) pulses++;
    end
    check_output("held_key_pulses", pulses, 1);
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();

    // CPU right win and restart timing.
    apply_stimulus(0, 5, 0, 0, 1);
    tick();
    apply_stimulus(0, 0, 1023, 0, 0);
    check_output("rwin_move_r", move_r, 1);
    check_output("rwin_score_r", score_r, 1);
    check_output("rwin_winner", winner, 1);
    tick(3);
    check_output("rwin_hold_no_clear", field_reset, 0);
    tick();
    check_output("rwin_clear", field_reset, 1);
    tick();
    check_output("rwin_clear_end", field_reset, 0);
    apply_stimulus(1, 0, 1023, 0, 0);
    tick();
    check_output("rwin_play_resumed", move_l, 1);
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();

    // Left win with the key held across the restart.
    pulses = 0;
    apply_stimulus(1, 0, 1023, 1, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) leftmost_on = 1'b0;
      if (move_l) pulses++;
    end
    check_output("held_across_clear_pulses", pulses, 1);
    check_output("lwin_score_l", score_l, 1);
    check_output("lwin_winner", winner, 0);
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();

    // Simultaneous requests.
    apply_stimulus(1, 5, 0, 0, 0);
    tick();
`ifdef WAR_ALT_PRIORITY_EN
    check_output("tie1_move_l", move_l, 1);
    check_output("tie1_move_r", move_r, 0);
`else
    check_output("tie1_move_l", move_l, 0);
    check_output("tie1_move_r", move_r, 0);
`endif
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();
    apply_stimulus(1, 5, 0, 0, 0);
    tick();
`ifdef WAR_ALT_PRIORITY_EN
    check_output("tie2_move_l", move_l, 0);
    check_output("tie2_move_r", move_r, 1);
`else
    check_output("tie2_move_l", move_l, 0);
    check_output("tie2_move_r", move_r, 0);
`endif
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();

    // Async reset with a move pulse in flight during the win hold.
    apply_stimulus(1, 0, 1023, 1, 0);
    tick();
    apply_stimulus(0, 0, 1023, 0, 0);
    check_output("rst_hold_move_l", move_l, 1);
    check_output("rst_hold_score_l", score_l, 2);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_hold");
    tick(2);
    reset_n = 1'b1;
    apply_stimulus(1, 0, 1023, 0, 0);
    tick();
    check_output("rst_play_move_l", move_l, 1);
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();

    // Seven left wins reach game over.
    for (int w = 1; w <= SMAX; w++) begin
      apply_stimulus(1, 0, 1023, 1, 0);
      tick();
      apply_stimulus(0, 0, 1023, 0, 0);
      check_output("seq_score_l", score_l, w);
      if (w < SMAX) tick(HOLD + 1);
    end
    tick(HOLD - 1);
    check_output("over_not_yet", game_over, 0);
    tick();
    check_output("over_set", game_over, 1);
    check_output("over_no_clear", field_reset, 0);
    apply_stimulus(1, 5, 0, 1, 1);
    tick(4);
    check_output("over_ignore_move_l", move_l, 0);
    check_output("over_ignore_move_r", move_r, 0);
    check_output("over_score_r", score_r, 0);
    check_output("over_sticky", game_over, 1);
    apply_stimulus(0, 0, 1023, 0, 0);
    tick();

    // Async reset from game over.
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_over");
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check_output("post_over_game_over", game_over, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
